// File: rtl/key_debounce.sv
// Purpose : two-key input conditioner. Synchronises active-low raw pins, filters bounce, emits press pulses.
// Latency : a clean raw edge reaches key_out exactly 2 + CNT_MAX rising edges later; pulses coincide with key_out change.
// Backpr. : none; free-running level path, pulses are single-cycle and cannot be stalled.
//
// Ports:
//   sys_clk     in   1  system clock, rising edge
//   sys_rst     in   1  synchronous active-high reset
//   key_in      in   2  raw key pins, active-low, asynchronous to sys_clk
//   key_out     out  2  debounced levels, same polarity as key_in, idle 2'b11
//   key_press   out  2  one-cycle pulse when key_out[i] goes 1->0
//   key_release out  2  one-cycle pulse when key_out[i] goes 0->1 (only with KEY_RELEASE_PULSE_EN)
//
// Optional build macro: KEY_RELEASE_PULSE_EN adds the key_release port and its edge logic.
module key_debounce #(
    parameter logic [19:0] CNT_MAX = 20'd1_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [1:0] key_in,
    output logic [1:0] key_out,
    output logic [1:0] key_press
`ifdef KEY_RELEASE_PULSE_EN
    ,
    output logic [1:0] key_release
`endif
);

    // Two-stage synchroniser; only s2 feeds the filter.
    logic [1:0]       s1;
    logic [1:0]       s2;

    // Per-key stability counters, fully independent.
    logic [1:0][19:0] cnt;
    logic [1:0][19:0] cnt_nxt;

    // accept[i]: this edge commits s2[i] into key_out[i].
    logic [1:0]       accept;

    always_comb begin
        accept  = 2'b00;
        cnt_nxt = '0;
        for (int i = 0; i < 2; i++) begin
            if (s2[i] == key_out[i]) begin
                // Any agreeing sample restarts the stability window.
                cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_MAX - 20'd1) begin
                // CNT_MAX consecutive differing samples seen: take the new level.
                accept[i]  = 1'b1;
                cnt_nxt[i] = '0;
            end else begin
                cnt_nxt[i] = cnt[i] + 20'd1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s1        <= 2'b11;
            s2        <= 2'b11;
            cnt       <= '0;
            key_out   <= 2'b11;
            key_press <= 2'b00;
        end else begin
            s1        <= key_in;
            s2        <= s1;
            cnt       <= cnt_nxt;
            // Accepted bits always differ from key_out, so toggling them installs s2.
            key_out   <= key_out ^ accept;
            // Accepting a 0 means the debounced level is falling: a press.
            key_press <= accept & ~s2;
        end
    end

`ifdef KEY_RELEASE_PULSE_EN
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            key_release <= 2'b00;
        end else begin
            // Accepting a 1 means the debounced level is rising: a release.
            key_release <= accept & s2;
        end
    end
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed scoreboard bench for key_debounce with CNT_MAX = 16.
// Stimulus pushes the expected key_out/pulse event with its cycle stamp; a monitor
// pops and compares whenever key_out changes or any pulse output is high.
module tb_key_debounce;

    localparam logic [19:0] CNT = 20'd16;
    localparam int          LAT = 2 + 16;
`ifdef KEY_RELEASE_PULSE_EN
    localparam logic [1:0]  REL_MASK = 2'b11;
`else
    localparam logic [1:0]  REL_MASK = 2'b00;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] key_in = 2'b11;
    logic [1:0] key_out;
    logic [1:0] key_press;
    logic [1:0] rel;

    key_debounce #(.CNT_MAX(CNT)) dut (
        .sys_clk    (clk),
        .sys_rst    (rst),
        .key_in     (key_in),
        .key_out    (key_out),
        .key_press  (key_press)
`ifdef KEY_RELEASE_PULSE_EN
        ,
        .key_release(rel)
`endif
    );
`ifndef KEY_RELEASE_PULSE_EN
    assign rel = 2'b00;
`endif

    always #10 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] out;
        logic [1:0] press;
        logic [1:0] rel;
    } ev_t;

    ev_t        q[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    bit         mon_en   = 1'b0;
    logic [1:0] prev_out = 2'b11;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [1:0] o, input logic [1:0] p, input logic [1:0] r);
        ev_t e;
        e.cyc   = c;
        e.out   = o;
        e.press = p;
        e.rel   = r & REL_MASK;
        q.push_back(e);
    endtask

    // Change key_in just after an edge; c is the edge count at that moment.
    task automatic drive(input logic [1:0] v, output int c);
        @(posedge clk);
        #1;
        key_in = v;
        c      = cyc;
    endtask

    // Keep the current key_in for n cycles in total (counted from its drive).
    task automatic hold(input int n);
        repeat (n - 1) @(posedge clk);
    endtask

    // Monitor: one scoreboard pop per observable event.
    always @(negedge clk) begin
        if (mon_en) begin
            if (key_out != prev_out || key_press != 2'b00 || rel != 2'b00) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event: cycle %0d key_out=%b key_press=%b key_release=%b, none expected",
                             cyc, key_out, key_press, rel);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    chk("event_cycle", cyc, e.cyc);
                    chk("event_key_out", int'(key_out), int'(e.out));
                    chk("event_key_press", int'(key_press), int'(e.press));
                    chk("event_key_release", int'(rel), int'(e.rel));
                end
            end
            prev_out = key_out;
        end
    end

    initial begin
        int c;
        int d;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_key_out", int'(key_out), 3);
        chk("reset_key_press", int'(key_press), 0);
        chk("reset_key_release", int'(rel), 0);
        chk("reset_cnt0", int'(dut.cnt[0]), 0);
        chk("reset_cnt1", int'(dut.cnt[1]), 0);
        prev_out = key_out;
        mon_en   = 1'b1;

        // Idle: nothing may happen for 100 cycles
        repeat (100) @(posedge clk);
        #1;
        chk("idle_key_out", int'(key_out), 3);
        chk("idle_cnt0", int'(dut.cnt[0]), 0);
        chk("idle_cnt1", int'(dut.cnt[1]), 0);

        // Clean press of key 0, then release
        drive(2'b10, c);
        push(c + LAT, 2'b10, 2'b01, 2'b00);
        hold(30);
        drive(2'b11, c);
        push(c + LAT, 2'b11, 2'b00, 2'b01);
        hold(30);

        // Bounce on key 1: low 5, high 3, low 7, high 10, then held low
        drive(2'b01, c); hold(5);
        drive(2'b11, c); hold(3);
        drive(2'b01, c); hold(7);
        drive(2'b11, c); hold(10);
        drive(2'b01, c);
        push(c + LAT, 2'b01, 2'b10, 2'b00);
        hold(30);
        drive(2'b11, c);
        push(c + LAT, 2'b11, 2'b00, 2'b10);
        hold(30);

        // Glitch one sample short of the threshold on key 0
        drive(2'b10, c); hold(15);
        drive(2'b11, c); hold(40);
        #1;
        chk("glitch_key_out", int'(key_out), 3);

        // Simultaneous press and release of both keys
        drive(2'b00, c);
        push(c + LAT, 2'b00, 2'b11, 2'b00);
        hold(30);
        drive(2'b11, c);
        push(c + LAT, 2'b11, 2'b00, 2'b11);
        hold(30);

        // Reset while key 0 is mid-filter with cnt[0] == 10
        drive(2'b10, c);
        hold(12);
        @(posedge clk);
        #1;
        chk("midfilter_cnt0", int'(dut.cnt[0]), 10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        d   = cyc;
        chk("midreset_key_out", int'(key_out), 3);
        chk("midreset_cnt0", int'(dut.cnt[0]), 0);
        push(d + LAT, 2'b10, 2'b01, 2'b00);
        hold(30);
        drive(2'b11, c);
        push(c + LAT, 2'b11, 2'b00, 2'b01);

        // Bounded drain of outstanding expectations
        for (int i = 0; i < 100; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
        end
        repeat (5) @(posedge clk);
        chk("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Input-conditioning stage for the two board push-buttons.
- Synchronises the raw active-low key pins to sys_clk, filters contact bounce with a per-key stability counter, and presents clean levels to the LED-pattern controller downstream.
- Also emits single-cycle press pulses for any consumer that needs edge events rather than levels.

Parameters:
- CNT_MAX, 20'd1_000_000, number of consecutive stable cycles required before a level change is accepted (20 ms at 50 MHz). Legal range is 2 to 2^20-1.

Ports:
- sys_clk  input  1  system clock, 50 MHz; all logic on the rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- key_in  input  2  raw push-button pins; active-low (0 = pressed); asynchronous to sys_clk.
- key_out  output  2  debounced key levels; same polarity as key_in; idle value 2'b11.
- key_press  output  2  one-cycle high pulse per key when its debounced level goes 1->0.

Behaviour:
- Reset, sampled on a sys_clk edge with sys_rst = 1:
  - both synchroniser stages <= 2'b11
  - key_out <= 2'b11
  - key_press <= 2'b00
  - both counters <= 0
- Reset overrides everything, including a filter in progress. After release, filtering restarts from count 0.
- Synchroniser: two flip-flop stages per bit, key_in -> s1 -> s2. Only s2 is used by the filter.
- Each key i has its own 20-bit counter cnt[i]. The two keys are fully independent.
- Per key i, each cycle:
  - If s2[i] == key_out[i]: cnt[i] <= 0.
  - Else if cnt[i] == CNT_MAX-1: key_out[i] <= s2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i] + 1.
- Bounce handling: any single sample of s2[i] equal to key_out[i] during counting clears cnt[i]. The change is accepted only after CNT_MAX consecutive differing samples.
- Latency: a clean raw edge on key_in[i] appears on key_out[i] exactly 2 + CNT_MAX rising edges later.
- key_press[i] is a registered pulse. It is high for exactly the one cycle immediately after key_out[i] changes 1->0, and 0 otherwise.
- A release (key_out 0->1) produces no pulse on key_press.
- Simultaneous events: both keys may update key_out and pulse key_press on the same cycle.
- Counter never wraps: it is cleared on acceptance or on agreement, so it cannot exceed CNT_MAX-1.
- A key held indefinitely gives one key_press pulse and a stable key_out[i] = 0. There is no auto-repeat.
- Downstream sees only filtered levels. The combination 2'b00 (both keys pressed) is passed through unchanged.

Optional Feature:
- Macro: KEY_RELEASE_PULSE_EN
- Defined:
  - Adds output port key_release, 2 bits, reset value 2'b00.
  - key_release[i] is high for the one cycle immediately after key_out[i] changes 0->1, with the same timing as key_press.
- Undefined:
  - The port does not exist.
  - No release-edge logic is built.
  - All other behaviour is identical.

Test Plan (CNT_MAX = 16 for simulation):
- Reset, then hold key_in = 2'b11 for 100 cycles -> key_out stays 2'b11, key_press stays 2'b00, both counters stay 0.
- Clean press: drive key_in[0] 1->0 and hold -> key_out[0] falls exactly 18 edges after the input edge; key_press = 2'b01 for exactly 1 cycle; key_out[1] stays 1.
- Bounce: toggle key_in[1] low/high with intervals of 5, 3, 7 and 10 cycles, then hold it low -> no change on key_out[1] during the bounce; key_out[1] falls 18 edges after the final low edge; one key_press[1] pulse only.
- Glitch rejection: pulse key_in[0] low for 15 cycles (one short of the threshold) -> key_out[0] never changes and key_press stays 0.
- Simultaneous press, then release, with KEY_RELEASE_PULSE_EN defined:
  - both keys low on the same edge -> key_out 2'b11 -> 2'b00 on one cycle; key_press = 2'b11 for 1 cycle.
  - release both -> key_release = 2'b11 for 1 cycle; key_press stays 0.
- Reset mid-filter: assert sys_rst for 1 cycle when cnt[0] = 10 with key_in[0] held low -> key_out[0] = 1 after reset; key_out[0] falls 18 edges after sys_rst deasserts.
